// File: rtl/rs232_fifo_transmitter.sv
// rs232_fifo_transmitter: pops FIFO words and sends them as UART frames,
// least-significant byte first, with optional parity and 1 or 2 stop bits.
module rs232_fifo_transmitter #(
   parameter int CLK_FREQ_HZ = 50000000,
   parameter int BAUD_RATE   = 115200,
   parameter int DATA_WIDTH  = 32,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  fifo_ready,
   input  logic                  fifo_empty,
   output logic                  fifo_pop,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  tx,
   output logic                  busy,
   output logic                  word_done
);
   localparam int BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE;
   localparam int BYTES    = DATA_WIDTH / 8;
   localparam int BW       = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int CW       = ($clog2(BAUD_DIV) > 16) ? $clog2(BAUD_DIV) : 16;

   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] BYTE_LAST = BW'(BYTES - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_POP, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [CW-1:0]         r_baud, w_baud_nxt;
   logic [2:0]            r_bit, w_bit_nxt;
   logic [BW-1:0]         r_byte, w_byte_nxt;
   logic [DATA_WIDTH-1:0] r_word, w_word_nxt;
   logic                  r_tx, r_pop, r_busy, r_done;
   logic                  w_tx_nxt, w_pop_nxt, w_busy_nxt, w_done_nxt;
   logic                  w_baud_end;
   logic [7:0]            w_cur;

   assign w_baud_end = (r_baud == BAUD_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_byte  <= '0;
         r_word  <= '0;
         r_tx    <= 1'b1;
         r_pop   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_byte  <= w_byte_nxt;
         r_word  <= w_word_nxt;
         r_tx    <= w_tx_nxt;
         r_pop   <= w_pop_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud;
      w_bit_nxt   = r_bit;
      w_byte_nxt  = r_byte;
      w_word_nxt  = r_word;
      unique case (r_state)
         S_IDLE: begin
            if (enable && fifo_ready && !fifo_empty) w_state_nxt = S_POP;
         end
         S_POP: w_state_nxt = S_LOAD;
         S_LOAD: begin
            w_word_nxt  = fifo_data;
            w_byte_nxt  = '0;
            w_baud_nxt  = '0;
            w_bit_nxt   = '0;
            w_state_nxt = S_START;
         end
         S_START: begin
            if (w_baud_end) begin
               w_baud_nxt  = '0;
               w_bit_nxt   = '0;
               w_state_nxt = S_DATA;
            end else begin
               w_baud_nxt = r_baud + 1'b1;
            end
         end
         S_DATA: begin
            if (w_baud_end) begin
               w_baud_nxt = '0;
               if (r_bit == 3'd7) begin
                  w_bit_nxt   = '0;
                  w_state_nxt = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
               end else begin
                  w_bit_nxt = r_bit + 1'b1;
               end
            end else begin
               w_baud_nxt = r_baud + 1'b1;
            end
         end
         S_PARITY: begin
            if (w_baud_end) begin
               w_baud_nxt  = '0;
               w_state_nxt = S_STOP;
            end else begin
               w_baud_nxt = r_baud + 1'b1;
            end
         end
         S_STOP: begin
            // r_bit counts stop bits here
            if (w_baud_end) begin
               w_baud_nxt = '0;
               if (r_bit == STOP_LAST) begin
                  w_bit_nxt = '0;
                  if (r_byte == BYTE_LAST) begin
                     w_byte_nxt  = '0;
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_byte_nxt  = r_byte + 1'b1;
                     w_state_nxt = S_START;
                  end
               end else begin
                  w_bit_nxt = r_bit + 1'b1;
               end
            end else begin
               w_baud_nxt = r_baud + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs are derived from next state so the registers line up with it
   always_comb begin
      w_cur      = 8'(w_word_nxt >> {w_byte_nxt, 3'b000});
      w_pop_nxt  = (w_state_nxt == S_POP);
      w_busy_nxt = (w_state_nxt != S_IDLE);
      w_done_nxt = (w_state_nxt == S_STOP) && (w_baud_nxt == BAUD_LAST) &&
                   (w_bit_nxt == STOP_LAST) && (w_byte_nxt == BYTE_LAST);
      w_tx_nxt   = 1'b1;
      unique case (w_state_nxt)
         S_START:  w_tx_nxt = 1'b0;
         S_DATA:   w_tx_nxt = w_cur[w_bit_nxt];
         S_PARITY: w_tx_nxt = (^w_cur) ^ (PARITY_MODE == 1);
         default:  w_tx_nxt = 1'b1;
      endcase
   end

   assign fifo_pop  = r_pop;
   assign tx        = r_tx;
   assign busy      = r_busy;
   assign word_done = r_done;

endmodule

// File: tb/tb_rs232_fifo_transmitter.sv
// tb_rs232_fifo_transmitter: three configurations of the transmitter fed
// by queue-based FIFO models and checked against an ideal bit-stream model.
module tb_rs232_fifo_transmitter;
   localparam int DIV = 8;

   typedef struct {
      logic [1:0]  inst;
      logic [31:0] word;
      int          nb;
      int          par;
      int          sb;
      int          exp_len;
      bit          b2b;
   } vec_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  en    = 3'b001;
   logic [2:0]  rdy   = 3'b111;
   logic [2:0]  emp   = 3'b111;
   logic [2:0]  pop, txo, busy, done;
   logic [31:0] d0    = '0;
   logic [7:0]  d1    = '0;
   logic [15:0] d2    = '0;
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic [31:0] q2[$];
   int          n_chk  = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   rs232_fifo_transmitter #(
      .CLK_FREQ_HZ(800), .BAUD_RATE(100), .DATA_WIDTH(32),
      .PARITY_MODE(0), .STOP_BITS(1)
   ) u0 (
      .clk(clk), .rst_n(rst_n), .enable(en[0]), .fifo_ready(rdy[0]),
      .fifo_empty(emp[0]), .fifo_pop(pop[0]), .fifo_data(d0),
      .tx(txo[0]), .busy(busy[0]), .word_done(done[0])
   );

   rs232_fifo_transmitter #(
      .CLK_FREQ_HZ(800), .BAUD_RATE(100), .DATA_WIDTH(8),
      .PARITY_MODE(2), .STOP_BITS(1)
   ) u1 (
      .clk(clk), .rst_n(rst_n), .enable(en[1]), .fifo_ready(rdy[1]),
      .fifo_empty(emp[1]), .fifo_pop(pop[1]), .fifo_data(d1),
      .tx(txo[1]), .busy(busy[1]), .word_done(done[1])
   );

   rs232_fifo_transmitter #(
      .CLK_FREQ_HZ(800), .BAUD_RATE(100), .DATA_WIDTH(16),
      .PARITY_MODE(1), .STOP_BITS(2)
   ) u2 (
      .clk(clk), .rst_n(rst_n), .enable(en[2]), .fifo_ready(rdy[2]),
      .fifo_empty(emp[2]), .fifo_pop(pop[2]), .fifo_data(d2),
      .tx(txo[2]), .busy(busy[2]), .word_done(done[2])
   );

   // FIFO models: data is valid the cycle after the pop strobe
   always @(posedge clk) begin
      if (pop[0] && q0.size() > 0) d0 <= q0.pop_front();
      if (pop[1] && q1.size() > 0) d1 <= 8'(q1.pop_front());
      if (pop[2] && q2.size() > 0) d2 <= 16'(q2.pop_front());
      emp <= {q2.size() == 0, q1.size() == 0, q0.size() == 0};
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_word(input logic [1:0] inst, input logic [31:0] w,
                             input int nb, input int par, input int sb,
                             input string nm, output int waited,
                             output int gap_low, output int len);
      bit         exp[$];
      logic [7:0] b;
      int         bad, dcnt, dpos, nbusy;
      bad = 0; dcnt = 0; dpos = -1; nbusy = 0;
      waited = 0; gap_low = 0;
      for (int i = 0; i < nb; i++) begin
         b = w[8*i +: 8];
         for (int k = 0; k < DIV; k++) exp.push_back(1'b0);
         for (int j = 0; j < 8; j++)
            for (int k = 0; k < DIV; k++) exp.push_back(b[j]);
         if (par != 0)
            for (int k = 0; k < DIV; k++)
               exp.push_back((^b) ^ (par == 1));
         for (int k = 0; k < sb * DIV; k++) exp.push_back(1'b1);
      end
      while (!pop[inst] && waited < 2000) begin
         if (!txo[inst]) gap_low++;
         @(negedge clk);
         waited++;
      end
      chk({nm, "_pop"}, int'(pop[inst]), 1);
      chk({nm, "_pop_cycle"}, int'({txo[inst], busy[inst]}), 3);
      @(negedge clk);
      chk({nm, "_load"}, int'({txo[inst], pop[inst], busy[inst]}), 5);
      for (int k = 0; k < exp.size(); k++) begin
         @(negedge clk);
         if (txo[inst] !== exp[k]) bad++;
         if (done[inst]) begin
            dcnt++;
            dpos = k;
         end
         if (!busy[inst]) nbusy++;
      end
      len = dpos + 1;
      chk({nm, "_tx_bit_errors"}, bad, 0);
      chk({nm, "_done_count"}, dcnt, 1);
      chk({nm, "_done_pos"}, dpos, exp.size() - 1);
      chk({nm, "_busy_low_cycles"}, nbusy, 0);
   endtask

   initial begin
      vec_t        tbl[4];
      int          waited, gap, len, cnt, t;
      logic [31:0] rw[6];

      tbl[0] = '{2'd0, 32'h44332211, 4, 0, 1, 320, 1'b0};
      tbl[1] = '{2'd1, 32'h000000A5, 1, 2, 1,  88, 1'b0};
      tbl[2] = '{2'd2, 32'h000000A5, 2, 1, 2, 192, 1'b0};
      tbl[3] = '{2'd2, 32'h00007F01, 2, 1, 2, 192, 1'b1};

      for (int i = 0; i < 4; i++) begin
         case (tbl[i].inst)
            2'd0:    q0.push_back(tbl[i].word);
            2'd1:    q1.push_back(tbl[i].word);
            default: q2.push_back(tbl[i].word);
         endcase
      end

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_hold", int'({txo[0], pop[0], busy[0], done[0]}), 8);
      end
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         en[tbl[i].inst] = 1'b1;
         check_word(tbl[i].inst, tbl[i].word, tbl[i].nb, tbl[i].par,
                    tbl[i].sb, $sformatf("vec%0d", i), waited, gap, len);
         chk($sformatf("vec%0d_len", i), len, tbl[i].exp_len);
         if (tbl[i].b2b) begin
            chk($sformatf("vec%0d_pop_after_done", i), waited, 2);
            chk($sformatf("vec%0d_gap_low", i), gap, 0);
         end
      end

      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         cnt += int'(pop[0]) + int'(!txo[0]);
      end
      chk("empty_no_pop", cnt, 0);

      rdy[0] = 1'b0;
      q0.push_back(32'hDEADBEEF);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         cnt += int'(pop[0]) + int'(!txo[0]);
      end
      chk("not_ready_no_pop", cnt, 0);
      rdy[0] = 1'b1;
      check_word(2'd0, 32'hDEADBEEF, 4, 0, 1, "ready_release",
                 waited, gap, len);

      q0.push_back(32'h0F0F1234);
      q0.push_back(32'hCAFEF00D);
      fork
         check_word(2'd0, 32'h0F0F1234, 4, 0, 1, "en_drop",
                    waited, gap, len);
         begin : drop
            int td;
            td = 0;
            while (!pop[0] && td < 2000) begin
               @(negedge clk);
               td++;
            end
            repeat (120) @(negedge clk);
            en[0] = 1'b0;
         end
      join
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         cnt += int'(pop[0]) + int'(!txo[0]);
      end
      chk("en_drop_idle", cnt, 0);
      chk("en_drop_queue_left", q0.size(), 1);
      en[0] = 1'b1;
      check_word(2'd0, 32'hCAFEF00D, 4, 0, 1, "en_resume",
                 waited, gap, len);

      q0.push_back(32'h89ABCDEF);
      t = 0;
      while (!pop[0] && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("midreset_pop", int'(pop[0]), 1);
      repeat (177) @(negedge clk);
      chk("midreset_busy_before", int'(busy[0]), 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midreset_out", int'({txo[0], pop[0], busy[0], done[0]}), 8);
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         cnt += int'(pop[0]) + int'(done[0]) + int'(!txo[0]);
      end
      chk("midreset_after_idle", cnt, 0);
      q0.push_back(32'h00FF00FF);
      check_word(2'd0, 32'h00FF00FF, 4, 0, 1, "fresh",
                 waited, gap, len);

      for (int i = 0; i < 6; i++) begin
         rw[i] = $urandom;
         q0.push_back(rw[i]);
      end
      for (int i = 0; i < 6; i++) begin
         check_word(2'd0, rw[i], 4, 0, 1, $sformatf("rnd%0d", i),
                    waited, gap, len);
         if (i > 0) begin
            chk($sformatf("rnd%0d_pop_after_done", i), waited, 2);
            chk($sformatf("rnd%0d_gap_low", i), gap, 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rs232_fifo_transmitter.md
# rs232_fifo_transmitter

Drains words from the transmit-side `fifo` and serialises them onto the RS232 TX line, so it acts as the reader/consumer end of the FIFO. It pops one DATA_WIDTH-bit word, then sends it as back-to-back UART frames, least-significant byte first. It has a built-in baud divider and supports optional parity and 1 or 2 stop bits. It sits between the FIFO's pop port and the board TX pin.

## Interface
- CLK_FREQ_HZ, 50000000, system clock frequency.
- BAUD_RATE, 115200, line rate. BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE, truncated; BAUD_DIV must be ≥ 2.
- DATA_WIDTH, 32, FIFO word width. Must be a multiple of 8; BYTES = DATA_WIDTH/8.
- PARITY_MODE, 0, parity selection: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- enable  in  1  permits starting a new word.
- fifo_ready  in  1  FIFO is usable (FIFO enable and not clear).
- fifo_empty  in  1  FIFO holds no data.
- fifo_pop  out  1  one-clock pop strobe to the FIFO.
- fifo_data  in  DATA_WIDTH  popped word. It is valid the cycle after fifo_pop.
- tx  out  1  serial line. Idles high.
- busy  out  1  high from the pop cycle until the last stop bit ends.
- word_done  out  1  one-clock pulse at the end of each word's final stop bit.

## Operation
- States: IDLE, POP, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx=1, busy=0. If enable, fifo_ready and !fifo_empty are all high, go to POP.
- POP: fifo_pop=1 for exactly this cycle, busy=1. Next state is LOAD.
- LOAD: capture fifo_data into the shift word, set byte_idx=0, then go to START.
- START: tx=0 for BAUD_DIV clocks, then go to DATA.
- DATA: send bits 0..7 of the current byte, LSB first, each for BAUD_DIV clocks. The current byte is shift word bits [8*byte_idx+7 : 8*byte_idx]. After bit 7, go to PARITY if PARITY_MODE≠0, otherwise to STOP.
- PARITY: even mode sends the XOR of the byte's 8 bits; odd mode sends its complement. Lasts BAUD_DIV clocks.
- STOP: tx=1 for STOP_BITS×BAUD_DIV clocks.
  - If byte_idx < BYTES-1: increment byte_idx and go to START. There is no gap between bytes.
  - Otherwise: pulse word_done and go to IDLE.
- Baud counter: 16 bits minimum. It counts 0..BAUD_DIV-1, and the bit advances when it reaches BAUD_DIV-1. It is reset to 0 on entry to START.
- bit_idx is 3 bits and byte_idx is $clog2(BYTES) bits (minimum 1). Neither wraps; the state transitions bound them.
- enable is sampled only in IDLE. Dropping it mid-word finishes the whole word and then stays in IDLE.
- fifo_empty and fifo_ready are ignored outside IDLE.
- The word captured in LOAD is held unchanged until the next LOAD.

## Timing
- Reset values: tx=1, fifo_pop=0, busy=0, word_done=0, state=IDLE, all counters 0.
- Reset asserted mid-frame returns all of the above at the next clock edge. The partial frame is abandoned and no word_done is produced.
- Start latency: the condition is true in IDLE at cycle N. Then fifo_pop=1 at N+1, LOAD at N+2, and the start bit's first tx=0 appears at N+3.
- Frame length: FRAME = (1 + 8 + (PARITY_MODE≠0) + STOP_BITS) × BAUD_DIV clocks.
- Word length: BYTES × FRAME clocks from the start of the first start bit.
- word_done is high during the last clock of the final stop bit. IDLE follows on the next clock.
- Back-to-back words: word_done at cycle M, IDLE at M+1, fifo_pop at M+2, next start bit at M+4. That gives exactly 3 extra idle-high clocks between words.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use CLK_FREQ_HZ=800, BAUD_RATE=100 (BAUD_DIV=8), DATA_WIDTH=32, PARITY_MODE=0, STOP_BITS=1 unless stated otherwise.
- Reset: hold rst_n=0 for 3 clocks with the FIFO non-empty -> tx=1, fifo_pop=0, busy=0 throughout.
- Single word 0x44332211 -> one fifo_pop pulse. tx sends bytes 0x11, 0x22, 0x33, 0x44, each as start 0, LSB-first data, stop 1. Every bit is 8 clocks; the word is 320 clocks total. word_done fires once, in the last of those clocks.
- PARITY_MODE=2, DATA_WIDTH=8, word 0xA5 -> bit sequence 0,1,0,1,0,0,1,0,1,0(parity),1. With PARITY_MODE=1, the parity bit is 1.
- STOP_BITS=2 with two words queued -> each stop period lasts 16 clocks of high. Exactly 3 extra high clocks separate word_done from the next start bit, and the second fifo_pop occurs 2 clocks after the first word_done.
- Edge cases:
  - fifo_empty=1 or fifo_ready=0 with enable=1 -> no pop, tx stays high.
  - enable dropped during byte 1 -> the whole word completes, then no further pop.
- Reset mid-DATA of byte 2 -> tx=1 and busy=0 on the next clock, no word_done. After release, a fresh word starts from byte 0.
